// File: rtl/vm_pkg.sv
// Shared VM definitions: loader states, frame target codes, instruction field widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vm_pkg;

    localparam int OPC_W  = 4;
    localparam int INSN_W = 12;

    typedef enum logic [2:0] {
        S_HUNT,
        S_TGT,
        S_ADDR,
        S_LEN,
        S_PHI,
        S_PLO,
        S_CSUM
    } loaderState_t;

    typedef enum logic [1:0] {
        TGT_PROG = 2'd0,
        TGT_DATA = 2'd1,
        TGT_RUN  = 2'd2
    } target_t;

    // Only codes 0..2 name a real target; anything wider is a framing error.
    function automatic logic tgtValid(input logic [7:0] b);
        return b <= {6'b0, TGT_RUN};
    endfunction

endpackage

// File: rtl/vm_image_loader_if.sv
// Host byte channel plus memory write ports and status of the image loader.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready handshake on the host byte channel.
interface vm_image_loader_if #(
    parameter int PAW = 8,
    parameter int DAW = 8
);
    import vm_pkg::*;

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              p_we;
    logic [PAW-1:0]    p_addr;
    logic [INSN_W-1:0] p_wdata;
    logic              d_we;
    logic [DAW-1:0]    d_addr;
    logic [7:0]        d_wdata;
    logic              core_hold;
    logic              busy;
    logic              err;
    logic [7:0]        frames_ok;

    modport master (
        output in_data, in_valid,
        input  in_ready, p_we, p_addr, p_wdata, d_we, d_addr, d_wdata,
        input  core_hold, busy, err, frames_ok
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, p_we, p_addr, p_wdata, d_we, d_addr, d_wdata,
        output core_hold, busy, err, frames_ok
    );
endinterface

// File: rtl/vm_word_counter.sv
// Loadable 9-bit remaining-word down-counter with zero flag, plus the wrapping write address.
// Latency: load/step take effect on the next clock edge.
// Backpressure: none; the owner steps it only on accepted payload words.
module vm_word_counter #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic [7:0]    loadVal,
    input  logic          ldAddr,
    input  logic          ldCnt,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic [8:0]    cnt,
    output logic          zero
);
    assign zero = (cnt == 9'd0);

    // Address and count load independently; a length byte of 0 means a full 256 words.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            addr <= '0;
            cnt  <= '0;
        end else begin
            if (ldAddr)
                addr <= AW'(loadVal);
            else if (step)
                addr <= addr + 1'b1;
            if (ldCnt)
                cnt <= (loadVal == 8'd0) ? 9'd256 : {1'b0, loadVal};
            else if (step)
                cnt <= cnt - 9'd1;
        end
    end
endmodule

// File: rtl/vm_image_loader.sv
// Framed byte-stream loader writing program/data memory images; holds the core until a good run frame.
// Latency: write strobe one cycle after the word-completing byte; core_hold changes one cycle after TGT/CSUM.
// Backpressure: never stalls the host; in_ready is high in every state once out of reset.
module vm_image_loader
    import vm_pkg::*;
#(
    parameter int         PAW  = 8,
    parameter int         DAW  = 8,
    parameter logic [7:0] SYNC = 8'hA5
) (
    input logic              eo3,
    input logic              nF3,
    vm_image_loader_if.slave bus
);
    localparam int AW = (PAW > DAW) ? PAW : DAW;

    loaderState_t     state;
    target_t          tgt;
    logic [7:0]       sum;
    logic [7:0]       sumNext;
    logic [OPC_W-1:0] hiNibble;
    logic             accept;
    logic             ctrLdAddr;
    logic             ctrLdCnt;
    logic             ctrStep;
    logic             ctrZero;
    logic [AW-1:0]    ctrAddr;
    logic [8:0]       ctrCnt;

    assign accept    = bus.in_valid && bus.in_ready;
    assign sumNext   = sum + bus.in_data;
    assign ctrLdAddr = accept && (state == S_ADDR);
    assign ctrLdCnt  = accept && (state == S_LEN);
    // The zero guard keeps a stray step from wrapping the count past the frame end.
    assign ctrStep   = accept && (state == S_PLO) && !ctrZero;
    assign bus.busy  = (state != S_HUNT);

    vm_word_counter #(.AW(AW)) u_counter (
        .clk     (eo3),
        .rstN    (nF3),
        .loadVal (bus.in_data),
        .ldAddr  (ctrLdAddr),
        .ldCnt   (ctrLdCnt),
        .step    (ctrStep),
        .addr    (ctrAddr),
        .cnt     (ctrCnt),
        .zero    (ctrZero)
    );

    // Frame parser: one accepted byte per transition, write strobes and status registered here.
    always_ff @(posedge eo3 or negedge nF3) begin
        if (!nF3) begin
            state         <= S_HUNT;
            tgt           <= TGT_PROG;
            sum           <= '0;
            hiNibble      <= '0;
            bus.in_ready  <= 1'b0;
            bus.p_we      <= 1'b0;
            bus.p_addr    <= '0;
            bus.p_wdata   <= '0;
            bus.d_we      <= 1'b0;
            bus.d_addr    <= '0;
            bus.d_wdata   <= '0;
            bus.core_hold <= 1'b1;
            bus.err       <= 1'b0;
            bus.frames_ok <= '0;
        end else begin
            bus.in_ready <= 1'b1;
            bus.p_we     <= 1'b0;
            bus.d_we     <= 1'b0;
            if (accept) begin
                case (state)
                    S_HUNT: begin
                        if (bus.in_data == SYNC) begin
                            state   <= S_TGT;
                            sum     <= '0;
                            bus.err <= 1'b0;
                        end
                    end
                    S_TGT: begin
                        sum <= sumNext;
                        if (!tgtValid(bus.in_data)) begin
                            bus.err <= 1'b1;
                            state   <= S_HUNT;
                        end else begin
                            tgt   <= target_t'(bus.in_data[1:0]);
                            state <= S_ADDR;
                            // Any reload halts the core before memory is touched.
                            if (bus.in_data[1:0] != TGT_RUN)
                                bus.core_hold <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        sum   <= sumNext;
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        sum <= sumNext;
                        case (tgt)
                            TGT_PROG: state <= S_PHI;
                            TGT_DATA: state <= S_PLO;
                            default:  state <= S_CSUM;
                        endcase
                    end
                    S_PHI: begin
                        sum      <= sumNext;
                        hiNibble <= bus.in_data[OPC_W-1:0];
                        state    <= S_PLO;
                    end
                    S_PLO: begin
                        sum <= sumNext;
                        if (tgt == TGT_PROG) begin
                            bus.p_we    <= 1'b1;
                            bus.p_addr  <= ctrAddr[PAW-1:0];
                            bus.p_wdata <= {hiNibble, bus.in_data};
                        end else begin
                            bus.d_we    <= 1'b1;
                            bus.d_addr  <= ctrAddr[DAW-1:0];
                            bus.d_wdata <= bus.in_data;
                        end
                        if (ctrCnt == 9'd1)
                            state <= S_CSUM;
                        else
                            state <= (tgt == TGT_PROG) ? S_PHI : S_PLO;
                    end
                    S_CSUM: begin
                        if (sumNext == 8'd0) begin
                            bus.frames_ok <= bus.frames_ok + 8'd1;
                            if (tgt == TGT_RUN)
                                bus.core_hold <= 1'b0;
                        end else begin
                            bus.err <= 1'b1;
                        end
                        state <= S_HUNT;
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vm_image_loader.sv
// Self-checking bench for vm_image_loader: frame stimulus, write scoreboard, status checks.
// Latency: expects write strobes one cycle after the completing byte.
// Backpressure: host waits on in_ready before presenting each byte.
module tb_vm_image_loader;
    import vm_pkg::*;

    logic eo3 = 1'b0;
    logic nF3 = 1'b0;

    vm_image_loader_if #(.PAW(8), .DAW(8)) bus ();

    vm_image_loader #(.PAW(8), .DAW(8), .SYNC(8'hA5)) dut (
        .eo3 (eo3),
        .nF3 (nF3),
        .bus (bus)
    );

    always #5 eo3 = ~eo3;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          expFrames   = 0;
    logic [20:0] expQ[$];
    logic [20:0] monObs;
    logic [20:0] monExp;
    logic [7:0]  f[$];
    logic [7:0]  s;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] wr(input logic isProg, input logic [7:0] a, input logic [11:0] d);
        return {isProg, a, d};
    endfunction

    // Write monitor: every strobe must match the next expected write.
    always @(negedge eo3) begin
        if (bus.p_we || bus.d_we) begin
            checkEq("we_excl", 32'(bus.p_we & bus.d_we), 32'd0);
            monObs = {bus.p_we, bus.p_we ? bus.p_addr : bus.d_addr,
                      bus.p_we ? bus.p_wdata : {4'h0, bus.d_wdata}};
            checkEq("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                monExp = expQ.pop_front();
                checkEq("write", 32'(monObs), 32'(monExp));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge eo3);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int tries = 0;
        @(negedge eo3);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && tries < 20) begin
            @(negedge eo3);
            tries++;
        end
        if (tries >= 20)
            checkEq("rdy_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic sendFrame(input logic [7:0] fr[$], input logic gaps);
        foreach (fr[i]) begin
            if (gaps)
                idle($urandom_range(0, 2));
            sendByte(fr[i]);
        end
        idle(2);
    endtask

    task automatic checkStatus(input string tag, input logic e, input logic h);
        checkEq({tag, "_err"}, 32'(bus.err), 32'(e));
        checkEq({tag, "_hold"}, 32'(bus.core_hold), 32'(h));
        checkEq({tag, "_frames"}, 32'(bus.frames_ok), 32'(expFrames));
        checkEq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkEq({tag, "_sb"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge eo3);
        checkEq("rst_ready", 32'(bus.in_ready), 32'd0);
        checkEq("rst_pwe", 32'(bus.p_we), 32'd0);
        checkEq("rst_dwe", 32'(bus.d_we), 32'd0);
        checkEq("rst_busy", 32'(bus.busy), 32'd0);
        checkEq("rst_err", 32'(bus.err), 32'd0);
        checkEq("rst_hold", 32'(bus.core_hold), 32'd1);
        checkEq("rst_frames", 32'(bus.frames_ok), 32'd0);
        checkEq("rst_paddr", 32'(bus.p_addr), 32'd0);
        checkEq("rst_pwdata", 32'(bus.p_wdata), 32'd0);
        checkEq("rst_daddr", 32'(bus.d_addr), 32'd0);
        checkEq("rst_dwdata", 32'(bus.d_wdata), 32'd0);
        nF3 = 1'b1;
        #1 checkEq("ready_low_at_release", 32'(bus.in_ready), 32'd0);
        @(negedge eo3);
        checkEq("ready_after_release", 32'(bus.in_ready), 32'd1);

        // Program frame
        expQ.push_back(wr(1'b1, 8'h10, 12'h82A));
        expQ.push_back(wr(1'b1, 8'h11, 12'hF05));
        f = '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h08, 8'h2A, 8'h0F, 8'h05, 8'hA8};
        sendFrame(f, 1'b0);
        expFrames = 1;
        checkStatus("prog", 1'b0, 1'b1);

        // Data frame wrapping from FF to 00
        expQ.push_back(wr(1'b0, 8'hFF, 12'h011));
        expQ.push_back(wr(1'b0, 8'h00, 12'h022));
        f = '{8'hA5, 8'h01, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCB};
        sendFrame(f, 1'b0);
        expFrames = 2;
        checkStatus("dwrap", 1'b0, 1'b1);

        // LEN=0 data frame: 256 words, checksum computed by the bench
        f = '{8'hA5, 8'h01, 8'h80, 8'h00};
        s = 8'h01 + 8'h80;
        for (int i = 0; i < 256; i++) begin
            f.push_back(8'(i) ^ 8'h5A);
            s = s + (8'(i) ^ 8'h5A);
            expQ.push_back(wr(1'b0, 8'h80 + 8'(i), {4'h0, 8'(i) ^ 8'h5A}));
        end
        f.push_back(8'h00 - s);
        sendFrame(f, 1'b0);
        expFrames = 3;
        checkStatus("len256", 1'b0, 1'b1);

        // Run frame: hold drops one cycle after CSUM is accepted
        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h00);
        sendByte(8'h00);
        sendByte(8'hFE);
        checkEq("run_hold_pre", 32'(bus.core_hold), 32'd1);
        idle(1);
        checkEq("run_hold_post", 32'(bus.core_hold), 32'd0);
        idle(1);
        expFrames = 4;
        checkStatus("run", 1'b0, 1'b0);

        // Program reload re-asserts hold one cycle after TGT
        expQ.push_back(wr(1'b1, 8'h10, 12'h82A));
        expQ.push_back(wr(1'b1, 8'h11, 12'hF05));
        sendByte(8'hA5);
        sendByte(8'h00);
        checkEq("reload_hold_pre", 32'(bus.core_hold), 32'd0);
        sendByte(8'h10);
        checkEq("reload_hold_post", 32'(bus.core_hold), 32'd1);
        f = '{8'h02, 8'h08, 8'h2A, 8'h0F, 8'h05, 8'hA8};
        sendFrame(f, 1'b0);
        expFrames = 5;
        checkStatus("reload", 1'b0, 1'b1);

        // Bad checksum on a run frame
        f = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'hFF};
        sendFrame(f, 1'b0);
        checkStatus("badcsum", 1'b1, 1'b1);

        // Leading junk dropped, SYNC clears err, bad target sets it again
        sendByte(8'h33);
        sendByte(8'hA5);
        checkEq("junk_busy", 32'(bus.busy), 32'd0);
        checkEq("junk_err_kept", 32'(bus.err), 32'd1);
        sendByte(8'h07);
        checkEq("sync_err_clr", 32'(bus.err), 32'd0);
        checkEq("sync_busy", 32'(bus.busy), 32'd1);
        idle(1);
        checkEq("badtgt_err", 32'(bus.err), 32'd1);
        checkEq("badtgt_busy", 32'(bus.busy), 32'd0);
        idle(1);
        checkStatus("badtgt", 1'b1, 1'b1);

        // Program frame with idle gaps between bytes
        expQ.push_back(wr(1'b1, 8'h10, 12'h82A));
        expQ.push_back(wr(1'b1, 8'h11, 12'hF05));
        f = '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h08, 8'h2A, 8'h0F, 8'h05, 8'hA8};
        sendFrame(f, 1'b1);
        expFrames = 6;
        checkStatus("gaps", 1'b0, 1'b1);

        // Reset between payload bytes discards the rest of the frame
        expQ.push_back(wr(1'b0, 8'h40, 12'h011));
        expQ.push_back(wr(1'b0, 8'h41, 12'h022));
        f = '{8'hA5, 8'h01, 8'h40, 8'h04, 8'h11, 8'h22};
        foreach (f[i]) sendByte(f[i]);
        idle(2);
        nF3 = 1'b0;
        #1;
        checkEq("mid_rst_busy", 32'(bus.busy), 32'd0);
        checkEq("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        checkEq("mid_rst_frames", 32'(bus.frames_ok), 32'd0);
        checkEq("mid_rst_daddr", 32'(bus.d_addr), 32'd0);
        checkEq("mid_rst_dwdata", 32'(bus.d_wdata), 32'd0);
        checkEq("mid_rst_hold", 32'(bus.core_hold), 32'd1);
        idle(2);
        nF3 = 1'b1;
        sendByte(8'h33);
        sendByte(8'h44);
        sendByte(8'h02);
        idle(3);
        expFrames = 0;
        checkStatus("after_rst", 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/vm_image_loader.md
Name: vm_image_loader

Overview:
- Byte-stream loader that writes program and data images into the VM's two memories: the 12-bit program memory and the 8-bit data memory.
- It is the writer-side counterpart of the core's fetch/load path.
- It holds the VM core in reset until a valid run frame arrives.
- It sits between a host byte channel (UART/JTAG bridge) and the memory write ports; its core_hold output feeds the core's synchronous reset.

Parameters:
- PAW, 8, program memory address width.
- DAW, 8, data memory address width.
- SYNC, 8'hA5, frame sync byte.

Ports:
- eo3  in  1  clock; all state changes on posedge.
- nF3  in  1  reset; asynchronous, active-low.
- in_data  in  8  host byte.
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader can accept a byte.
- p_we  out  1  program memory write strobe.
- p_addr  out  PAW  program memory write address.
- p_wdata  out  12  program word: {opcode[3:0], operand[7:0]}.
- d_we  out  1  data memory write strobe.
- d_addr  out  DAW  data memory write address.
- d_wdata  out  8  data byte.
- core_hold  out  1  holds the VM core in reset while high.
- busy  out  1  a frame is in progress (state is not S_HUNT).
- err  out  1  sticky frame error.
- frames_ok  out  8  count of good frames, wraps at 255 to 0.

Behaviour:
- Reset (nF3=0, async) values:
  - state = S_HUNT.
  - in_ready, p_we, d_we, busy, err = 0; core_hold = 1.
  - All addresses, write data and frames_ok = 0.
  - Assertion is honoured immediately, even mid-frame; any partial frame is discarded.
- in_ready = 1 in every state once out of reset (registered; first high in the cycle after deassertion).
- A byte is accepted only on a cycle with in_valid && in_ready.
- Frame format: SYNC, TGT, ADDR, LEN, payload, CSUM.
  - TGT: 0 = program, 1 = data, 2 = run.
  - LEN = 0 means 256 words.
  - Payload for program: 2 bytes per word, hi byte first; hi[3:0] is the opcode, hi[7:4] is ignored.
  - Payload for data: 1 byte per word.
  - Payload for run: none; ADDR and LEN are received and ignored.
- CSUM rule: the 8-bit sum of TGT, ADDR, LEN, all payload bytes and CSUM must equal 8'h00. A running 8-bit sum register is cleared on SYNC.
- FSM states: S_HUNT, S_TGT, S_ADDR, S_LEN, S_PHI, S_PLO, S_CSUM.
  - S_HUNT: non-SYNC bytes are dropped; SYNC goes to S_TGT and clears err.
  - S_TGT: TGT > 2 sets err and returns to S_HUNT.
  - S_ADDR, S_LEN: latch the start address and the 9-bit word count.
  - After S_LEN: program goes to S_PHI, data goes to S_PLO, run goes to S_CSUM.
  - S_PHI: latch the hi byte, go to S_PLO.
  - S_PLO: completes a word; decrement the remaining count; go to S_CSUM when it reaches 0, else to S_PHI (program) or stay in S_PLO (data).
  - S_CSUM: always returns to S_HUNT.
- Writes:
  - p_we/d_we is a one-cycle pulse, registered, in the cycle after the byte that completes a word is accepted.
  - The address starts at ADDR and increments per word, wrapping modulo 2**PAW (program) or 2**DAW (data).
  - Payload writes are issued as bytes arrive, before CSUM is checked. A bad frame may therefore leave partial contents; the host must resend.
- CSUM good:
  - frames_ok increments.
  - If TGT is run, core_hold falls to 0 in the next cycle.
- CSUM bad: err = 1; frames_ok and core_hold are unchanged.
- Any accepted program or data frame re-asserts core_hold = 1 in the cycle after its TGT byte is accepted. Reloading therefore always halts the core.
- A SYNC value inside the payload is treated as data; there is no resynchronisation mid-frame.
- p_we and d_we are never high in the same cycle.

Decomposition:
- Shared package vm_pkg:
  - typedef enum for loader states.
  - Target codes TGT_PROG, TGT_DATA, TGT_RUN.
  - Constants OPC_W = 4 and INSN_W = 12, shared with the core decode.
- Sub-module vm_word_counter: a loadable 9-bit down-counter with a zero flag, which also tracks the wrapping write address. It is natural to split out because it is reused by the planned memory dump reader.

Test Plan:
- Program frame:
  - Stimulus: A5 00 10 02 08 2A 0F 05 A8.
  - Required: p_we pulses with p_addr=10 / p_wdata=82A, then p_addr=11 / p_wdata=F05; err=0; frames_ok=1; core_hold stays 1.
- Data frame with address wrap:
  - Stimulus: A5 01 FF 02 11 22 CB.
  - Required: d_we pulses with d_addr=FF / d_wdata=11, then d_addr=00 / d_wdata=22; frames_ok increments.
- Run frame:
  - Stimulus: A5 02 00 00 FE.
  - Required: core_hold goes 1->0 one cycle after the CSUM byte is accepted.
  - Follow-up: a subsequent program frame re-asserts core_hold one cycle after its TGT byte.
- Bad checksum and bad target:
  - Stimulus: A5 02 00 00 FF.
  - Required: err=1, core_hold stays 1, frames_ok unchanged.
  - Stimulus: 33 A5 ...
  - Required: the leading 33 is dropped and err clears on the A5.
  - Stimulus: TGT=07.
  - Required: err=1 and the FSM returns to S_HUNT.
- Gaps and reset:
  - Stimulus: in_valid toggling with idle gaps during the payload.
  - Required: writes identical to the gapless case.
  - Stimulus: nF3 asserted between payload bytes.
  - Required: outputs take reset values immediately; no further writes from that frame.
